conv_compute_ctrl: RTL and testbench
====================================

Name: conv_compute_ctrl

Overview:
Control unit for the convolution compute/output stage. It sits directly downstream of the X- and F-vector write controls.
- Waits until both input memories are loaded.
- Sequences synchronous reads of the X and F memories and drives the MAC accumulator enables.
- Presents each output Y over a valid/ready handshake.
- When all outputs are delivered, pulses mem_wr_done to rearm the write controls for the next vector pair.

Parameters:
INPUT_N, 16, number of X-vector entries
LG_INPUT_N, 4, log2(INPUT_N)
FILTER_N, 8, number of F-vector taps
LG_FILTER_N, 3, log2(FILTER_N)
(derived localparam) OUTPUT_N = INPUT_N - FILTER_N + 1, default 9

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
done_x  input  1  X-memory fully written (level, from X write control)
done_f  input  1  F-memory fully written (level, from F write control)
mem_wr_state  output  1  high while write controls may fill memories
mem_wr_done  output  1  one-cycle pulse: compute finished, write controls reset addresses
addr_x  output  LG_INPUT_N  X-memory read address
addr_f  output  LG_FILTER_N  F-memory read address
rd_en  output  1  read enable to both memories (1-cycle read latency)
acc_load  output  1  accumulator <= product (first tap of an output)
acc_en  output  1  accumulator <= accumulator + product
m_valid_y  output  1  Y output valid
m_ready_y  input  1  downstream ready for Y
done_y  output  1  high during the handshake cycle of the final output

Behaviour:
- Reset values, synchronous: state=WRITE, j=0, k=0; all outputs 0 except mem_wr_state=1. Reset mid-operation aborts any computation and returns to WRITE; mem_wr_done is not pulsed.
- Counters:
  - j is the output index, 0..OUTPUT_N-1.
  - k is the tap index, 0..FILTER_N-1.
  - addr_f = k; addr_x = j + k, truncated to LG_INPUT_N. The maximum value INPUT_N-1 never overflows.
- States:
  - WRITE: mem_wr_state=1. When done_x & done_f are both high, go to MAC next cycle with k=0 and j=0.
  - MAC: rd_en=1, one tap per cycle. k increments each cycle. After the k=FILTER_N-1 cycle, go to DRAIN.
  - DRAIN: single cycle. rd_en=0. Accounts for the last read's data.
  - OUT: m_valid_y=1, held stable until m_valid_y & m_ready_y. On that handshake:
    - if j==OUTPUT_N-1, go to FLUSH;
    - else j++, k=0, go to MAC.
  - FLUSH: single cycle. mem_wr_done=1, j=0. Go to WRITE.
- Accumulator timing: acc_load and acc_en are rd_en delayed by one cycle.
  - acc_load is asserted for the delayed k=0 read.
  - acc_en is asserted for delayed k>=1 reads.
  - They are never both high.
  - Per output: exactly 1 acc_load and FILTER_N-1 acc_en pulses.
- Latency: first m_valid_y rises FILTER_N+2 cycles after the cycle in which done_x & done_f is first sampled high. That is WRITE→MAC (1), MAC (FILTER_N), DRAIN (1).
- mem_wr_state is 0 in all states except WRITE. Write controls therefore cannot overwrite memory during compute.
- done_y = m_valid_y & (j==OUTPUT_N-1).
- Boundary conditions:
  - done_x high without done_f, or the reverse: stay in WRITE.
  - done_x/done_f deasserting in any non-WRITE state: ignored.
  - m_ready_y high outside OUT: ignored.
  - m_ready_y held high continuously: one output every FILTER_N+2 cycles.
  - Inputs still high when returning to WRITE: re-sampled one cycle after FLUSH. The write controls clear them on mem_wr_done.
- Parameter check: FILTER_N must be less than or equal to INPUT_N, enforced by elaboration-time assertion.

Test Plan:
- Defaults, reset then done_x=done_f=1 at cycle 0 → MAC cycles 1-8 with addr_f=0..7 and addr_x=0..7; acc_load at cycle 2; acc_en cycles 3-9; m_valid_y rises at cycle 10.
- m_ready_y tied high → 9 outputs, one every 10 cycles; output j uses addr_x=j..j+7; done_y only with the 9th; mem_wr_done pulses once; mem_wr_state returns to 1.
- m_ready_y low for 5 cycles during output 3 → m_valid_y held 6 cycles; addr/j unchanged; no extra acc pulses.
- done_f=1 and done_x=0 for 20 cycles → stays in WRITE with rd_en=0 and m_valid_y=0; compute starts 1 cycle after done_x rises.
- Assert reset during MAC of output 4 → next cycle all outputs are reset values; no mem_wr_done; full restart yields 9 outputs from j=0.
- INPUT_N=8, FILTER_N=8 → exactly one output; addr_x=0..7; done_y on that output; FLUSH follows.

Source files
------------

// File: rtl/conv_compute_ctrl.sv
// conv_compute_ctrl
// -----------------
// Sequencer for the convolution compute/output stage. It waits for the X and F
// write controls to report full memories, then for each output index j walks
// the taps k = 0..FILTER_N-1 and issues one synchronous read per cycle. The MAC
// accumulator controls follow the reads one cycle later. Each finished output
// is presented on a valid/ready handshake. After the last output it pulses
// mem_wr_done so the write controls rearm for the next vector pair.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   done_x        X memory fully written (level)
//   done_f        F memory fully written (level)
//   mem_wr_state  high only while the write controls may fill the memories
//   mem_wr_done   one-cycle pulse after the final output has been accepted
//   addr_x        X read address (j + k)
//   addr_f        F read address (k)
//   rd_en         read enable to both memories (1-cycle read latency)
//   acc_load      accumulator <= product (tap 0 data arriving)
//   acc_en        accumulator <= accumulator + product (taps 1.. arriving)
//   m_valid_y     Y output valid
//   m_ready_y     downstream ready for Y
//   done_y        valid cycle of the final output
module conv_compute_ctrl #(
  parameter int INPUT_N     = 16,
  parameter int LG_INPUT_N  = 4,
  parameter int FILTER_N    = 8,
  parameter int LG_FILTER_N = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done_x,
  input  logic                   done_f,
  output logic                   mem_wr_state,
  output logic                   mem_wr_done,
  output logic [LG_INPUT_N-1:0]  addr_x,
  output logic [LG_FILTER_N-1:0] addr_f,
  output logic                   rd_en,
  output logic                   acc_load,
  output logic                   acc_en,
  output logic                   m_valid_y,
  input  logic                   m_ready_y,
  output logic                   done_y
);

  localparam int OUTPUT_N = INPUT_N - FILTER_N + 1;
  localparam logic [LG_INPUT_N-1:0]  J_LAST = LG_INPUT_N'(OUTPUT_N - 1);
  localparam logic [LG_FILTER_N-1:0] K_LAST = LG_FILTER_N'(FILTER_N - 1);

  // A filter longer than the input leaves no valid output positions.
  generate
    if (FILTER_N > INPUT_N) begin : g_bad_filter_n
      $error("conv_compute_ctrl: FILTER_N (%0d) must not exceed INPUT_N (%0d)",
             FILTER_N, INPUT_N);
    end
    if ((1 << LG_INPUT_N) < INPUT_N) begin : g_bad_lg_input_n
      $error("conv_compute_ctrl: LG_INPUT_N too small for INPUT_N");
    end
    if ((1 << LG_FILTER_N) < FILTER_N) begin : g_bad_lg_filter_n
      $error("conv_compute_ctrl: LG_FILTER_N too small for FILTER_N");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_WRITE,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_FLUSH
  } state_t;

  state_t                 state_reg, state_next;
  logic [LG_INPUT_N-1:0]  j_reg, j_next;
  logic [LG_FILTER_N-1:0] k_reg, k_next;
  logic                   acc_load_reg;
  logic                   acc_en_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_WRITE;
      j_reg        <= '0;
      k_reg        <= '0;
      acc_load_reg <= 1'b0;
      acc_en_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      j_reg        <= j_next;
      k_reg        <= k_next;
      // Memory data arrives one cycle after the read; the tap index of that
      // read decides whether the accumulator restarts or keeps summing.
      acc_load_reg <= rd_en & (k_reg == '0);
      acc_en_reg   <= rd_en & (k_reg != '0);
    end
  end

  always_comb begin
    state_next   = state_reg;
    j_next       = j_reg;
    k_next       = k_reg;
    mem_wr_state = 1'b0;
    mem_wr_done  = 1'b0;
    rd_en        = 1'b0;
    m_valid_y    = 1'b0;
    done_y       = 1'b0;

    case (state_reg)
      S_WRITE: begin
        mem_wr_state = 1'b1;
        if (done_x && done_f) begin
          state_next = S_MAC;
          j_next     = '0;
          k_next     = '0;
        end
      end

      S_MAC: begin
        rd_en = 1'b1;
        if (k_reg == K_LAST) begin
          // Wrap explicitly so non-power-of-two filters also restart at 0.
          k_next     = '0;
          state_next = S_DRAIN;
        end else begin
          k_next = k_reg + LG_FILTER_N'(1);
        end
      end

      // One idle cycle lets the final tap's read data reach the accumulator.
      S_DRAIN: begin
        state_next = S_OUT;
      end

      S_OUT: begin
        m_valid_y = 1'b1;
        done_y    = (j_reg == J_LAST);
        if (m_ready_y) begin
          if (j_reg == J_LAST) begin
            state_next = S_FLUSH;
          end else begin
            j_next     = j_reg + LG_INPUT_N'(1);
            k_next     = '0;
            state_next = S_MAC;
          end
        end
      end

      S_FLUSH: begin
        mem_wr_done = 1'b1;
        j_next      = '0;
        state_next  = S_WRITE;
      end

      default: begin
        state_next = S_WRITE;
      end
    endcase
  end

  // j + k peaks at INPUT_N-1, so the sum never wraps in LG_INPUT_N bits.
  assign addr_f   = k_reg;
  assign addr_x   = j_reg + LG_INPUT_N'(k_reg);
  assign acc_load = acc_load_reg;
  assign acc_en   = acc_en_reg;

endmodule

// File: tb/tb_conv_compute_ctrl.sv
// Testbench for conv_compute_ctrl. Two instances share one stimulus stream:
// the default 16/8 configuration and an 8/8 configuration that yields a
// single output. Each instance has a phase-counting reference model that is
// compared every cycle; directed literal checks pin the model timing.
module tb_conv_compute_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset     = 1'b1;
  logic done_x    = 1'b0;
  logic done_f    = 1'b0;
  logic m_ready_y = 1'b0;
  logic armed     = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int IN_N  = (gi == 0) ? 16 : 8;
      localparam int LG_IN = (gi == 0) ? 4 : 3;
      localparam int F_N   = 8;
      localparam int LG_F  = 3;
      localparam int OUT_N = IN_N - F_N + 1;

      logic            mem_wr_state, mem_wr_done, rd_en, acc_load, acc_en;
      logic            m_valid_y, done_y;
      logic [LG_IN-1:0] addr_x;
      logic [LG_F-1:0]  addr_f;

      conv_compute_ctrl #(
        .INPUT_N    (IN_N),
        .LG_INPUT_N (LG_IN),
        .FILTER_N   (F_N),
        .LG_FILTER_N(LG_F)
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .done_x      (done_x),
        .done_f      (done_f),
        .mem_wr_state(mem_wr_state),
        .mem_wr_done (mem_wr_done),
        .addr_x      (addr_x),
        .addr_f      (addr_f),
        .rd_en       (rd_en),
        .acc_load    (acc_load),
        .acc_en      (acc_en),
        .m_valid_y   (m_valid_y),
        .m_ready_y   (m_ready_y),
        .done_y      (done_y)
      );

      // Model: mode 0 = waiting for memories, 1 = computing, 2 = flush cycle.
      // While computing, p counts cycles within the current output:
      // 0..F_N-1 reads, F_N drain, F_N+1 waiting for the handshake.
      int   mode = 0;
      int   oj   = 0;
      int   p    = 0;
      logic exp_load = 1'b0;
      logic exp_en   = 1'b0;

      always @(negedge clk) begin : model
        logic e_rd;
        logic e_valid;
        e_rd    = (mode == 1) && (p < F_N);
        e_valid = (mode == 1) && (p == F_N + 1);
        if (armed) begin
          chk($sformatf("cfg%0d mem_wr_state", gi), 32'(mem_wr_state), 32'(mode == 0));
          chk($sformatf("cfg%0d mem_wr_done", gi), 32'(mem_wr_done), 32'(mode == 2));
          chk($sformatf("cfg%0d rd_en", gi), 32'(rd_en), 32'(e_rd));
          chk($sformatf("cfg%0d acc_load", gi), 32'(acc_load), 32'(exp_load));
          chk($sformatf("cfg%0d acc_en", gi), 32'(acc_en), 32'(exp_en));
          chk($sformatf("cfg%0d m_valid_y", gi), 32'(m_valid_y), 32'(e_valid));
          chk($sformatf("cfg%0d done_y", gi), 32'(done_y), 32'(e_valid && (oj == OUT_N - 1)));
          if (e_rd) begin
            chk($sformatf("cfg%0d addr_f", gi), 32'(addr_f), 32'(p));
            chk($sformatf("cfg%0d addr_x", gi), 32'(addr_x), 32'(oj + p));
          end
        end
        if (reset) begin
          mode     = 0;
          oj       = 0;
          p        = 0;
          exp_load = 1'b0;
          exp_en   = 1'b0;
        end else begin
          exp_load = e_rd && (p == 0);
          exp_en   = e_rd && (p != 0);
          case (mode)
            0: if (done_x && done_f) begin
                 mode = 1;
                 oj   = 0;
                 p    = 0;
               end
            1: if (p < F_N + 1) begin
                 p++;
               end else if (m_ready_y) begin
                 if (oj == OUT_N - 1) mode = 2;
                 else begin
                   oj++;
                   p = 0;
                 end
               end
            default: begin
              mode = 0;
              oj   = 0;
            end
          endcase
        end
      end
    end
  endgenerate

  initial begin
    int hs;
    int ndy;
    int nwd;
    int nvh;

    // Reset state.
    @(posedge clk); #1;
    armed = 1'b1;
    @(negedge clk);
    chk("rst mem_wr_state", 32'(g_cfg[0].mem_wr_state), 32'd1);
    chk("rst rd_en", 32'(g_cfg[0].rd_en), 32'd0);
    chk("rst m_valid_y", 32'(g_cfg[0].m_valid_y), 32'd0);
    chk("rst addr_x", 32'(g_cfg[0].addr_x), 32'd0);
    chk("rst addr_f", 32'(g_cfg[0].addr_f), 32'd0);
    chk("rst acc_load", 32'(g_cfg[0].acc_load), 32'd0);
    chk("rst mem_wr_done", 32'(g_cfg[0].mem_wr_done), 32'd0);

    @(posedge clk); #1;
    reset     = 1'b0;
    m_ready_y = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Run with ready tied high; cycle 0 is the cycle both dones are high.
    done_x = 1'b1;
    done_f = 1'b1;
    @(negedge clk);
    chk("a0 rd_en", 32'(g_cfg[0].rd_en), 32'd0);
    hs = 0; ndy = 0; nwd = 0;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        done_x = 1'b0;
        done_f = 1'b0;
      end
      @(negedge clk);
      hs  += int'(g_cfg[0].m_valid_y & m_ready_y);
      ndy += int'(g_cfg[0].done_y);
      nwd += int'(g_cfg[0].mem_wr_done);
      if (c == 1) begin
        chk("a1 rd_en", 32'(g_cfg[0].rd_en), 32'd1);
        chk("a1 addr_x", 32'(g_cfg[0].addr_x), 32'd0);
        chk("a1 mem_wr_state", 32'(g_cfg[0].mem_wr_state), 32'd0);
      end
      if (c == 2) begin
        chk("a2 acc_load", 32'(g_cfg[0].acc_load), 32'd1);
        chk("a2 addr_f", 32'(g_cfg[0].addr_f), 32'd1);
      end
      if (c == 8) begin
        chk("a8 addr_x", 32'(g_cfg[0].addr_x), 32'd7);
        chk("a8 cfg1 addr_x", 32'(g_cfg[1].addr_x), 32'd7);
      end
      if (c == 9) begin
        chk("a9 acc_en", 32'(g_cfg[0].acc_en), 32'd1);
        chk("a9 m_valid_y", 32'(g_cfg[0].m_valid_y), 32'd0);
      end
      if (c == 10) begin
        chk("a10 m_valid_y", 32'(g_cfg[0].m_valid_y), 32'd1);
        chk("a10 acc_en", 32'(g_cfg[0].acc_en), 32'd0);
        chk("a10 cfg1 done_y", 32'(g_cfg[1].done_y), 32'd1);
      end
      if (c == 11) begin
        chk("a11 cfg1 mem_wr_done", 32'(g_cfg[1].mem_wr_done), 32'd1);
        chk("a11 addr_x", 32'(g_cfg[0].addr_x), 32'd1);
      end
      if (c == 12) chk("a12 cfg1 mem_wr_state", 32'(g_cfg[1].mem_wr_state), 32'd1);
      if (c == 90) chk("a90 done_y", 32'(g_cfg[0].done_y), 32'd1);
      if (c == 92) chk("a92 mem_wr_state", 32'(g_cfg[0].mem_wr_state), 32'd1);
    end
    chk("a outputs", 32'(hs), 32'd9);
    chk("a done_y count", 32'(ndy), 32'd1);
    chk("a mem_wr_done count", 32'(nwd), 32'd1);

    // Only done_f high: must stay in WRITE.
    done_f = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("b wait rd_en", 32'(g_cfg[0].rd_en), 32'd0);
      chk("b wait m_valid_y", 32'(g_cfg[0].m_valid_y), 32'd0);
    end
    @(posedge clk); #1;
    done_x = 1'b1;
    @(negedge clk);
    hs = 0; ndy = 0; nwd = 0; nvh = 0;
    for (int b = 1; b <= 150; b++) begin
      @(posedge clk); #1;
      if (b == 1 || b == 51) begin
        done_x = 1'b0;
        done_f = 1'b0;
      end
      if (b == 50) begin
        done_x = 1'b1;
        done_f = 1'b1;
      end
      m_ready_y = !(b >= 40 && b < 45);
      reset     = (b == 48);
      @(negedge clk);
      if (b == 1) chk("b1 rd_en", 32'(g_cfg[0].rd_en), 32'd1);
      if (b >= 40 && b <= 45) begin
        nvh += int'(g_cfg[0].m_valid_y);
        chk("b hold acc_en", 32'(g_cfg[0].acc_en | g_cfg[0].acc_load), 32'd0);
      end
      if (b == 46) chk("b46 m_valid_y", 32'(g_cfg[0].m_valid_y), 32'd0);
      if (b <= 50) nwd += int'(g_cfg[0].mem_wr_done);
      if (b == 49) begin
        chk("b49 mem_wr_state", 32'(g_cfg[0].mem_wr_state), 32'd1);
        chk("b49 rd_en", 32'(g_cfg[0].rd_en), 32'd0);
        chk("b49 acc_en", 32'(g_cfg[0].acc_en), 32'd0);
        chk("b49 addr_x", 32'(g_cfg[0].addr_x), 32'd0);
      end
      if (b == 51) chk("b51 addr_x", 32'(g_cfg[0].addr_x), 32'd0);
      if (b > 50) begin
        hs  += int'(g_cfg[0].m_valid_y & m_ready_y);
        ndy += int'(g_cfg[0].done_y);
      end
      if (b == 140) chk("b140 done_y", 32'(g_cfg[0].done_y), 32'd1);
      if (b == 141) chk("b141 mem_wr_done", 32'(g_cfg[0].mem_wr_done), 32'd1);
    end
    chk("b hold cycles", 32'(nvh), 32'd6);
    chk("b no early mem_wr_done", 32'(nwd), 32'd0);
    chk("b restart outputs", 32'(hs), 32'd9);
    chk("b restart done_y", 32'(ndy), 32'd1);

    // Randomized traffic, checked by the models alone.
    for (int r = 0; r < 4000; r++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 249) == 0);
      done_x    = ($urandom_range(0, 3) != 0);
      done_f    = ($urandom_range(0, 3) != 0);
      m_ready_y = $urandom_range(0, 1) != 0;
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
